// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b type definitions: word and byte-mask types plus the memory responder FSM encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    mem_idle    = 2'd0,
    mem_wait    = 2'd1,
    mem_resp_st = 2'd2
  } lc3b_mem_state;

  localparam int LC3B_MEM_MAX_LATENCY = 15;

endpackage

// File: rtl/lc3b_mem_array.sv
// Word-organised storage with a synchronous byte-enable write port and a registered read port.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [1:0]            wmask,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  lc3b_word mem_q [0:(1<<DEPTH_LOG2)-1];
  lc3b_word rdata_q;
  lc3b_word rdata_d;

  // Read register holds its value until the next read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[index];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage is deliberately not reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we && wmask[0]) begin
      mem_q[index][7:0] <= wdata[7:0];
    end
    if (we && wmask[1]) begin
      mem_q[index][15:8] <= wdata[15:8];
    end
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 16'h0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: fixed-latency FSM in front of lc3b_mem_array.
// Optional LC3B_MEM_STATS_EN adds completed read/write counters.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_wmask,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        busy
`ifdef LC3B_MEM_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes
`endif
);

  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam bit         LAT_ONE = (LATENCY == 1);

  lc3b_mem_state         state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  lc3b_word              wdata_q, wdata_d;
  lc3b_mem_wmask         wmask_q, wmask_d;
  logic                  op_write_q, op_write_d;
  logic                  resp_q, resp_d;
  logic                  busy_q, busy_d;
  logic                  req_s, commit_s, arr_we_s, arr_re_s;
  logic                  unused_addr_s;

  assign req_s         = mem_read | mem_write;
  assign unused_addr_s = ^{mem_address[15:DEPTH_LOG2+1], mem_address[0]};

  // Next state, wait counter and request latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    op_write_d = op_write_q;
    case (state_q)
      mem_idle: begin
        if (req_s) begin
          idx_d      = mem_address[DEPTH_LOG2:1];
          wdata_d    = mem_wdata;
          wmask_d    = mem_wmask;
          op_write_d = ~mem_read;
          cnt_d      = LAT_M1;
          state_d    = LAT_ONE ? mem_resp_st : mem_wait;
        end else begin
          state_d = mem_idle;
        end
      end
      mem_wait: begin
        if (!req_s) begin
          state_d = mem_idle;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = mem_resp_st;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      mem_resp_st: state_d = mem_idle;
      default:     state_d = mem_idle;
    endcase
  end

  // Array access fires on the edge that enters RESP, using the latched (or just-accepted) request.
  always_comb begin
    commit_s = (state_q != mem_resp_st) && (state_d == mem_resp_st);
    arr_we_s = commit_s & op_write_d;
    arr_re_s = commit_s & ~op_write_d;
    resp_d   = (state_d == mem_resp_st);
    busy_d   = (state_d != mem_idle);
  end

  // FSM state, latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= mem_idle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      wmask_q    <= 2'b00;
      op_write_q <= 1'b0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      op_write_q <= op_write_d;
      resp_q     <= resp_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_resp = resp_q;
  assign busy     = busy_q;

  lc3b_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we_s),
    .re    (arr_re_s),
    .wmask (wmask_d),
    .index (idx_d),
    .wdata (wdata_d),
    .rdata (mem_rdata)
  );

`ifdef LC3B_MEM_STATS_EN
  logic [15:0] stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d;

  // Completed-transaction counters; aborted requests never reach commit.
  always_comb begin
    stat_reads_d  = stat_reads_q + (arr_re_s ? 16'd1 : 16'd0);
    stat_writes_d = stat_writes_q + (arr_we_s ? 16'd1 : 16'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads_q  <= 16'h0000;
      stat_writes_q <= 16'h0000;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed self-checking bench: LATENCY=4 instance (table + corner sequences) and a LATENCY=1 instance.
module tb_lc3b_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [1:0]  wm0, wm1;
  logic [15:0] ad0, wd0, ad1, wd1;
  logic        resp0, resp1, busy0, busy1;
  logic [15:0] rdata0, rdata1;
`ifdef LC3B_MEM_STATS_EN
  logic [15:0] sr0, sw0, sr1, sw1;
`endif

  int tests;
  int fails;
  int nreads0, nwrites0;

  lc3b_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .mem_wmask(wm0),
    .mem_address(ad0), .mem_wdata(wd0), .mem_resp(resp0), .mem_rdata(rdata0), .busy(busy0)
`ifdef LC3B_MEM_STATS_EN
    , .stat_reads(sr0), .stat_writes(sw0)
`endif
  );

  lc3b_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .mem_wmask(wm1),
    .mem_address(ad1), .mem_wdata(wd1), .mem_resp(resp1), .mem_rdata(rdata1), .busy(busy1)
`ifdef LC3B_MEM_STATS_EN
    , .stat_reads(sr1), .stat_writes(sw1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit which, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    if (which) begin
      rd1 = rd; wr1 = wr; ad1 = a; wd1 = d; wm1 = m;
    end else begin
      rd0 = rd; wr0 = wr; ad0 = a; wd0 = d; wm0 = m;
    end
  endtask

  // Full transaction: checks busy, latency, rdata and a one-cycle resp pulse.
  task automatic txn(input bit which, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] m, input logic [15:0] exp_rdata,
                     input string name);
    int  cyc;
    bit  got;
    int  exp_lat;
    cyc = 0;
    got = 1'b0;
    exp_lat = which ? 1 : 4;
    drive(which, rd, wr, a, d, m);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({name, "_busy"}, {31'd0, which ? busy1 : busy0}, 32'd1);
      if (which ? resp1 : resp0) got = 1'b1;
    end
    chk({name, "_lat"}, cyc, exp_lat);
    chk({name, "_rdata"}, {16'd0, which ? rdata1 : rdata0}, {16'd0, exp_rdata});
    drive(which, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    chk({name, "_pulse"}, {31'd0, which ? resp1 : resp0}, 32'd0);
    chk({name, "_idle"}, {31'd0, which ? busy1 : busy0}, 32'd0);
    if (!which) begin
      if (rd) nreads0++;
      else nwrites0++;
    end
  endtask

  // Watches dut for n cycles and expects no response.
  task automatic no_resp(input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (resp0) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int cyc;
    tests = 0; fails = 0; nreads0 = 0; nwrites0 = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);

    vecs[0]  = '{1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 16'h0040, 16'h1234, 2'b01, 16'hBEEF};
    vecs[3]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hBE34};
    vecs[4]  = '{1'b0, 1'b1, 16'h0040, 16'hAB00, 2'b10, 16'hBE34};
    vecs[5]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hAB34};
    vecs[6]  = '{1'b0, 1'b1, 16'h0041, 16'h5555, 2'b00, 16'hAB34};
    vecs[7]  = '{1'b1, 1'b0, 16'h0041, 16'h0000, 2'b00, 16'hAB34};
    vecs[8]  = '{1'b0, 1'b1, 16'h0842, 16'hC0DE, 2'b11, 16'hAB34};
    vecs[9]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00, 16'hC0DE};
    vecs[10] = '{1'b0, 1'b1, 16'h0044, 16'h7E57, 2'b11, 16'hC0DE};
    vecs[11] = '{1'b1, 1'b0, 16'h0844, 16'h0000, 2'b00, 16'h7E57};

    repeat (2) @(negedge clk);
    chk("reset_resp", {31'd0, resp0}, 32'd0);
    chk("reset_rdata", {16'd0, rdata0}, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
          vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Aborted read after two WAIT cycles.
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00);
    repeat (2) @(negedge clk);
    chk("abort_rd_busy", {31'd0, busy0}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    no_resp(8, "abort_rd_noresp");
    chk("abort_rd_idle", {31'd0, busy0}, 32'd0);
    chk("abort_rd_rdata", {16'd0, rdata0}, 32'h7E57);

    // Aborted write leaves memory intact.
    drive(1'b0, 1'b0, 1'b1, 16'h0040, 16'hFFFF, 2'b11);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    no_resp(8, "abort_wr_noresp");
    txn(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hAB34, "abort_wr_readback");

    // Reset during WAIT of a write.
    drive(1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 2'b11);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    chk("rst_mid_resp", {31'd0, resp0}, 32'd0);
    chk("rst_mid_rdata", {16'd0, rdata0}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
    rst = 1'b0;
    nreads0 = 0; nwrites0 = 0;
    no_resp(6, "rst_mid_noresp");
    txn(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00, 16'hC0DE, "rst_write_absent");
    txn(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hAB34, "rst_data_kept");

    // Read and write together: read wins.
    txn(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000, 2'b00, 16'h7E57, "pre_both");
    txn(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 2'b11, 16'hAB34, "both_rd");
    txn(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hAB34, "both_wr_absent");

    // Address change after acceptance is ignored.
    drive(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000, 2'b00);
    @(negedge clk);
    ad0 = 16'h0040;
    cyc = 1;
    while (!resp0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("addr_latch_lat", cyc, 4);
    chk("addr_latch_rdata", {16'd0, rdata0}, 32'h7E57);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    nreads0++;
    @(negedge clk);

    // Held read across RESP: second response LATENCY+1 cycles later.
    drive(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00);
    cyc = 0;
    while (!resp0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_lat", cyc, 4);
    cyc = 0;
    @(negedge clk);
    cyc++;
    chk("b2b_gap", {31'd0, resp0}, 32'd0);
    while (!resp0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_second_lat", cyc, 5);
    chk("b2b_rdata", {16'd0, rdata0}, 32'hC0DE);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    nreads0 += 2;
    @(negedge clk);

    // LATENCY=1 instance.
    txn(1'b1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 2'b11, 16'h0000, "lat1_wr");
    txn(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hA5A5, "lat1_rd");

`ifdef LC3B_MEM_STATS_EN
    chk("stat_reads", {16'd0, sr0}, nreads0);
    chk("stat_writes", {16'd0, sw0}, nwrites0);
    chk("stat_reads_lat1", {16'd0, sr1}, 32'd1);
    chk("stat_writes_lat1", {16'd0, sw1}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
